// File: rtl/watch_input_sequencer.sv
// Watch front end: 1 Hz / blink timebase, button conditioning, mode mirror and timeout auto-return.
// Latency: raw level to strobe is DEBOUNCE_CYCLES+3 cycles; timeout strobes 1 cycle after detection.
// Backpressure: none; strobes are single-cycle pulses the datapath must accept.
module watch_input_sequencer #(
    parameter int CLK_HZ              = 100_000_000,
    parameter int DEBOUNCE_CYCLES     = 1_000_000,
    parameter int REPEAT_DELAY_CYCLES = 50_000_000,
    parameter int REPEAT_RATE_CYCLES  = 10_000_000,
    parameter int TIMEOUT_S           = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       raw_mode,
    input  logic       raw_add,
    input  logic       raw_sub,
    output logic       pulse_1hz,
    output logic       pulse_500ms,
    output logic       mode_button,
    output logic       add_button,
    output logic       sub_button,
    output logic [1:0] set_mode
);

    localparam int TB_W   = $clog2(CLK_HZ);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ? REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int RP_W   = $clog2(RP_MAX + 1);
    localparam int TO_W   = $clog2(TIMEOUT_S + 1);

    localparam logic [TB_W-1:0] TB_LAST  = TB_W'(CLK_HZ - 1);
    localparam logic [TB_W-1:0] TB_HALF  = TB_W'(CLK_HZ / 2);
    localparam logic [DB_W-1:0] DB_LIM   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [RP_W-1:0] REP_DLY  = RP_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RP_W-1:0] REP_RATE = RP_W'(REPEAT_RATE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LIM   = TO_W'(TIMEOUT_S);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_RETURN = 1'b1;

    logic [TB_W-1:0] tb_q;
    logic [2:0]      sync1_q, sync2_q, stable_q, stable_dly_q, stable_d, press;
    logic [DB_W-1:0] db_cnt_q [3];
    logic [DB_W-1:0] db_cnt_d [3];
    logic [RP_W-1:0] rep_q [2];
    logic [RP_W-1:0] rep_d [2];
    logic [1:0]      rep_evt;
    logic [0:0]      state_q, state_d;
    logic            phase_q, phase_d;
    logic [TO_W-1:0] inact_q, inact_d;
    logic [1:0]      set_mode_q;
    logic            mode_q, add_q, sub_q, mode_d, add_d, sub_d;
    logic            both_held, add_evt, sub_evt, in_set, usr_add, usr_sub, usr_emit, timeout;

    assign pulse_1hz   = (tb_q == TB_LAST);
    assign pulse_500ms = (tb_q < TB_HALF);
    assign mode_button = mode_q;
    assign add_button  = add_q;
    assign sub_button  = sub_q;
    assign set_mode    = set_mode_q;

    // Index 0 = mode, 1 = add, 2 = sub; repeat counters cover add/sub only.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            stable_d[i] = stable_q[i];
            db_cnt_d[i] = db_cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LIM) begin
                stable_d[i] = ~stable_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
        press = stable_q & ~stable_dly_q;
        for (int j = 0; j < 2; j++) begin
            rep_evt[j] = 1'b0;
            rep_d[j]   = rep_q[j];
            if (press[j+1]) begin
                rep_d[j] = REP_DLY;
            end else if (!stable_q[j+1]) begin
                rep_d[j] = '0;
            end else if (rep_q[j] == '0) begin
                rep_evt[j] = 1'b1;
                rep_d[j]   = REP_RATE;
            end else begin
                rep_d[j] = rep_q[j] - 1'b1;
            end
        end
    end

    always_comb begin
        both_held = stable_q[1] & stable_q[2];
        add_evt   = press[1] | (rep_evt[0] & ~both_held);
        sub_evt   = press[2] | (rep_evt[1] & ~both_held);
        in_set    = (set_mode_q != 2'd0);
        usr_add   = add_evt & ~sub_evt & ~press[0] & in_set;
        usr_sub   = sub_evt & ~add_evt & ~press[0] & in_set;
        timeout   = in_set & (inact_q == TO_LIM);
        state_d   = state_q;
        phase_d   = phase_q;
        mode_d    = 1'b0;
        add_d     = 1'b0;
        sub_d     = 1'b0;
        usr_emit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (timeout) begin
                    state_d = ST_RETURN;
                    mode_d  = 1'b1;
                    phase_d = 1'b1;
                end else begin
                    mode_d   = press[0];
                    add_d    = usr_add;
                    sub_d    = usr_sub;
                    usr_emit = press[0] | usr_add | usr_sub;
                end
            end
            ST_RETURN: begin
                // Alternate cycles so each strobe reaches the mirror before the next decision.
                if (!in_set) begin
                    state_d = ST_IDLE;
                end else if (phase_q) begin
                    phase_d = 1'b0;
                end else begin
                    mode_d  = 1'b1;
                    phase_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        inact_d = inact_q;
        if (!in_set || usr_emit) begin
            inact_d = '0;
        end else if (pulse_1hz && inact_q != TO_LIM) begin
            inact_d = inact_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tb_q         <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
            for (int j = 0; j < 2; j++) rep_q[j] <= '0;
            state_q      <= ST_IDLE;
            phase_q      <= 1'b0;
            inact_q      <= '0;
            set_mode_q   <= 2'd0;
            mode_q       <= 1'b0;
            add_q        <= 1'b0;
            sub_q        <= 1'b0;
        end else begin
            tb_q         <= (tb_q == TB_LAST) ? '0 : tb_q + 1'b1;
            sync1_q      <= {raw_sub, raw_add, raw_mode};
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
            for (int j = 0; j < 2; j++) rep_q[j] <= rep_d[j];
            state_q      <= state_d;
            phase_q      <= phase_d;
            inact_q      <= inact_d;
            set_mode_q   <= set_mode_q + {1'b0, mode_q};
            mode_q       <= mode_d;
            add_q        <= add_d;
            sub_q        <= sub_d;
        end
    end

endmodule

// File: tb/tb_watch_input_sequencer.sv
// Bench for watch_input_sequencer: directed button sequences, expected strobes queued with
// their cycle index and checked by an independent monitor on the falling edge.
module tb_watch_input_sequencer;

    localparam int CLK = 20;
    localparam int MODE_K = 4;
    localparam int ADD_K  = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       raw_mode = 1'b0, raw_add = 1'b0, raw_sub = 1'b0;
    logic       pulse_1hz, pulse_500ms, mode_button, add_button, sub_button;
    logic [1:0] set_mode;

    typedef struct { int kind; int cyc; } exp_t;
    exp_t exp_q[$];
    int   cyc;
    int   total = 0;
    int   bad   = 0;

    watch_input_sequencer #(
        .CLK_HZ(CLK), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY_CYCLES(10),
        .REPEAT_RATE_CYCLES(3), .TIMEOUT_S(2)
    ) dut (
        .clock(clock), .reset(reset),
        .raw_mode(raw_mode), .raw_add(raw_add), .raw_sub(raw_sub),
        .pulse_1hz(pulse_1hz), .pulse_500ms(pulse_500ms),
        .mode_button(mode_button), .add_button(add_button), .sub_button(sub_button),
        .set_mode(set_mode)
    );

    always #5 clock = ~clock;

    // Cycle index: number of rising edges since reset release.
    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clock) begin
        if (reset) begin
            int   kind;
            exp_t e;
            total++;
            if (pulse_1hz !== ((cyc % CLK) == CLK - 1) || pulse_500ms !== ((cyc % CLK) < CLK / 2)) begin
                bad++;
                $display("FAIL timebase cyc=%0d: got 1hz=%b 500ms=%b expected 1hz=%b 500ms=%b",
                         cyc, pulse_1hz, pulse_500ms, (cyc % CLK) == CLK - 1, (cyc % CLK) < CLK / 2);
            end
            kind = int'({mode_button, add_button, sub_button});
            if (kind != 0) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL strobe: got kind %0d at cyc %0d, expected none", kind, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != kind || e.cyc != cyc) begin
                        bad++;
                        $display("FAIL strobe: got kind %0d at cyc %0d, expected kind %0d at cyc %0d",
                                 kind, cyc, e.kind, e.cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    // Value applied at cycle c is first sampled by the DUT at rising edge c+1.
    task automatic drive(input int c, input logic m, input logic a, input logic s);
        wait_cyc(c);
        raw_mode = m;
        raw_add  = a;
        raw_sub  = s;
    endtask

    task automatic chk_mode(input int c, input int v);
        wait_cyc(c);
        chk($sformatf("set_mode@%0d", c), int'(set_mode), v);
    endtask

    task automatic expect_stb(input int k, input int c);
        exp_t e;
        e.kind = k;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input logic hold_mode);
        @(negedge clock);
        chk("missing_strobes", exp_q.size(), 0);
        exp_q.delete();
        reset    = 1'b0;
        raw_mode = hold_mode;
        raw_add  = 1'b0;
        raw_sub  = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_pulse_1hz", int'(pulse_1hz), 0);
        chk("rst_pulse_500ms", int'(pulse_500ms), 1);
        chk("rst_strobes", int'({mode_button, add_button, sub_button}), 0);
        chk("rst_set_mode", int'(set_mode), 0);
        #1 reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Timebase only.
        do_reset(1'b0);
        wait_cyc(45);

        // Four mode presses wrap the mirror back to RUN.
        do_reset(1'b0);
        expect_stb(MODE_K, 12); expect_stb(MODE_K, 32);
        expect_stb(MODE_K, 52); expect_stb(MODE_K, 72);
        drive(4, 1, 0, 0); chk_mode(12, 0); chk_mode(13, 1); drive(14, 0, 0, 0);
        drive(24, 1, 0, 0); drive(30, 0, 0, 0); chk_mode(33, 2);
        drive(44, 1, 0, 0); drive(50, 0, 0, 0); chk_mode(53, 3);
        drive(64, 1, 0, 0); drive(70, 0, 0, 0); chk_mode(73, 0);
        wait_cyc(80);

        // Timeout from SET_MINUTES; an add press landing in RETURN is ignored.
        do_reset(1'b0);
        expect_stb(MODE_K, 12); expect_stb(MODE_K, 29);
        expect_stb(MODE_K, 61); expect_stb(MODE_K, 63);
        drive(4, 1, 0, 0); drive(10, 0, 0, 0);
        drive(21, 1, 0, 0); drive(26, 0, 0, 0); chk_mode(30, 2);
        drive(55, 0, 1, 0); drive(60, 0, 0, 0); chk_mode(60, 2);
        chk_mode(62, 3); chk_mode(64, 0);
        wait_cyc(100);

        // Glitches and RUN gating of add.
        do_reset(1'b0);
        expect_stb(MODE_K, 39); expect_stb(ADD_K, 57);
        drive(4, 0, 1, 0); drive(7, 0, 0, 0);
        drive(14, 0, 1, 0); drive(22, 0, 0, 0);
        drive(31, 1, 0, 0); drive(37, 0, 0, 0); chk_mode(40, 1);
        drive(44, 0, 1, 0); drive(47, 0, 0, 0);
        drive(49, 0, 1, 0); drive(55, 0, 0, 0);
        wait_cyc(75);

        // Auto-repeat on a 30-cycle add hold.
        do_reset(1'b0);
        expect_stb(MODE_K, 12);
        for (int t = 27; t <= 55; t += (t == 27) ? 10 : 3) expect_stb(ADD_K, t);
        drive(4, 1, 0, 0); drive(10, 0, 0, 0);
        drive(19, 0, 1, 0); drive(49, 0, 0, 0);
        chk_mode(60, 1);
        wait_cyc(70);

        // Mode beats add; add with sub cancels both, repeats included.
        do_reset(1'b0);
        expect_stb(MODE_K, 12); expect_stb(MODE_K, 27);
        drive(4, 1, 0, 0); drive(10, 0, 0, 0);
        drive(19, 1, 1, 0); drive(25, 0, 0, 0); chk_mode(28, 2);
        drive(34, 0, 1, 1); drive(49, 0, 0, 0); chk_mode(58, 2);

        // Mode held through reset is taken as a fresh press after full debounce.
        do_reset(1'b1);
        expect_stb(MODE_K, 8);
        chk_mode(8, 0); chk_mode(9, 1);
        drive(12, 0, 0, 0);
        wait_cyc(25);

        chk("missing_strobes", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
